// File: rtl/mc_unit_sched_if.sv
// mc_unit_sched_if: handshake between the clmul sequencer (master) and the iterative multiplier (slave)
interface mc_unit_sched_if #(parameter int XLEN = 32);
  logic              unit_start;
  logic              unit_stall;
  logic [XLEN-1:0]   unit_a;
  logic [XLEN-1:0]   unit_b;
  logic              unit_eoc;
  logic [2*XLEN-1:0] unit_res;
  logic [XLEN-1:0]   unit_res_r;
  modport master(output unit_start, unit_stall, unit_a, unit_b, input unit_eoc, unit_res, unit_res_r);
  modport slave(input unit_start, unit_stall, unit_a, unit_b, output unit_eoc, unit_res, unit_res_r);
endinterface

// File: rtl/mc_unit_sched.sv
// mc_unit_sched: sequences one iterative carry-less multiply per EX op, caching the last 64-bit product
module mc_unit_sched #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ext_stall,
  input  logic            flush,
  input  logic            req,
  input  logic [1:0]      op_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall_req,
  output logic [XLEN-1:0] res,
  output logic            err_timeout,
  mc_unit_sched_if.master u
);
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] c_a_q, c_a_d, c_b_q, c_b_d, c_lo_q, c_lo_d, c_hi_q, c_hi_d, c_r_q, c_r_d;
  logic [XLEN-1:0] unit_a_q, unit_a_d, unit_b_q, unit_b_d;
  logic c_valid_q, c_valid_d, err_q, err_d;
  logic hit, start, tmo;
  // Gating with reset keeps stale cache contents from hitting while reset is held
  assign hit = req && c_valid_q && !reset && op_a == c_a_q && op_b == c_b_q;
  assign stall_req = req && !hit && !flush;
  assign res = !hit ? '0 : op_sel == 2'd0 ? c_lo_q : op_sel == 2'd1 ? c_hi_q : op_sel == 2'd2 ? c_r_q : '0;
  assign start = state_q == IDLE && req && !hit && !flush && !ext_stall && !reset;
  assign tmo = cnt_q == CNT_W'(TIMEOUT - 1);
  assign err_timeout = err_q;
  assign u.unit_start = start;
  assign u.unit_stall = ext_stall;
  assign u.unit_a = unit_a_q;
  assign u.unit_b = unit_b_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    c_a_d     = c_a_q;
    c_b_d     = c_b_q;
    c_lo_d    = c_lo_q;
    c_hi_d    = c_hi_q;
    c_r_d     = c_r_q;
    c_valid_d = c_valid_q;
    unit_a_d  = unit_a_q;
    unit_b_d  = unit_b_q;
    if (start) begin
      unit_a_d = op_a;
      unit_b_d = op_b;
      cnt_d    = '0;
      state_d  = BUSY;
    end else if (state_q == BUSY && !ext_stall) begin
      if (flush) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end else if (u.unit_eoc) begin
        c_a_d     = unit_a_q;
        c_b_d     = unit_b_q;
        c_lo_d    = u.unit_res[XLEN-1:0];
        c_hi_d    = u.unit_res[2*XLEN-1:XLEN];
        c_r_d     = u.unit_res_r;
        c_valid_d = 1'b1;
        state_d   = IDLE;
      end else if (tmo) begin
        err_d     = 1'b1;
        c_a_d     = unit_a_q;
        c_b_d     = unit_b_q;
        c_lo_d    = '0;
        c_hi_d    = '0;
        c_r_d     = '0;
        c_valid_d = 1'b1;
        state_d   = IDLE;
      end else cnt_d = cnt_q + 1'b1;
    end else if (state_q == DRAIN && !ext_stall) begin
      if (u.unit_eoc) state_d = IDLE;
      else if (tmo) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      c_a_q     <= '0;
      c_b_q     <= '0;
      c_lo_q    <= '0;
      c_hi_q    <= '0;
      c_r_q     <= '0;
      c_valid_q <= 1'b0;
      unit_a_q  <= '0;
      unit_b_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      c_a_q     <= c_a_d;
      c_b_q     <= c_b_d;
      c_lo_q    <= c_lo_d;
      c_hi_q    <= c_hi_d;
      c_r_q     <= c_r_d;
      c_valid_q <= c_valid_d;
      unit_a_q  <= unit_a_d;
      unit_b_q  <= unit_b_d;
    end
  end
endmodule

// File: tb/tb_mc_unit_sched.sv
// tb_mc_unit_sched: directed checks of the clmul sequencer against a 4-cycle multiplier model
module tb_mc_unit_sched;
  logic clk = 1'b0, reset, ext_stall, flush, req;
  logic [1:0] op_sel;
  logic [31:0] op_a, op_b, res;
  logic stall_req, err_timeout;
  logic [63:0] prod;
  logic m_busy;
  logic [2:0] m_cnt;
  bit no_eoc;
  int errors = 0, checks = 0, starts = 0, overlap = 0;
  mc_unit_sched_if #(.XLEN(32)) mif ();
  mc_unit_sched #(.XLEN(32), .TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .flush(flush), .req(req), .op_sel(op_sel),
    .op_a(op_a), .op_b(op_b), .stall_req(stall_req), .res(res), .err_timeout(err_timeout), .u(mif)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] clmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r = '0;
    for (int i = 0; i < 32; i++) if (b[i]) r = r ^ ({32'b0, a} << i);
    return r;
  endfunction
  // Multiplier model: eoc in the 4th non-frozen cycle after start
  always @(posedge clk) begin
    if (mif.unit_start) starts <= starts + 1;
    if (mif.unit_start && m_busy) overlap <= overlap + 1;
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
    end else if (mif.unit_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 3'd4;
    end else if (m_busy && !mif.unit_stall) begin
      if (mif.unit_eoc) m_busy <= 1'b0;
      else if (m_cnt > 3'd1) m_cnt <= m_cnt - 3'd1;
    end
  end
  assign prod = clmul(mif.unit_a, mif.unit_b);
  assign mif.unit_eoc = m_busy && m_cnt == 3'd1 && !no_eoc;
  assign mif.unit_res = prod;
  assign mif.unit_res_r = prod[62:31];
  task automatic next;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1; ext_stall = 0; flush = 0; req = 1; op_sel = 0; op_a = 3; op_b = 5; no_eoc = 0;
    next(); next();
    @(negedge clk);
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL reset_stall got %b want 1", stall_req); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res got %h want 0", res); end
    checks++; if (mif.unit_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", mif.unit_start); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_timeout); end
    checks++; if (mif.unit_a !== 32'h0) begin errors++; $display("FAIL reset_unit_a got %h want 0", mif.unit_a); end
    req = 0;
    next();
    reset = 0;
  endtask
  task automatic test_basic;
    int s0 = starts;
    req = 1; op_sel = 0; op_a = 3; op_b = 5;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (stall_req !== (c < 5)) begin errors++; $display("FAIL basic_stall c%0d got %b want %b", c, stall_req, c < 5); end
      checks++; if (mif.unit_start !== (c == 0)) begin errors++; $display("FAIL basic_start c%0d got %b want %b", c, mif.unit_start, c == 0); end
      next();
    end
    checks++; if (res !== 32'hF) begin errors++; $display("FAIL basic_res got %h want f", res); end
    checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL basic_starts got %0d want 1", starts - s0); end
  endtask
  task automatic test_cache_hit;
    int n = 0;
    int s0 = starts;
    op_a = 32'h80000000; op_b = 32'h80000000; op_sel = 0; req = 1;
    @(negedge clk);
    while (stall_req && n < 30) begin @(negedge clk); n++; end
    checks++; if (n !== 5) begin errors++; $display("FAIL hit_miss_latency got %0d want 5", n); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL hit_clmul got %h want 0", res); end
    next(); op_sel = 1;
    @(negedge clk);
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL hit_clmulh_stall got %b want 0", stall_req); end
    checks++; if (res !== 32'h40000000) begin errors++; $display("FAIL hit_clmulh got %h want 40000000", res); end
    next(); op_sel = 2;
    @(negedge clk);
    checks++; if (res !== 32'h80000000) begin errors++; $display("FAIL hit_clmulr got %h want 80000000", res); end
    checks++; if (mif.unit_start !== 1'b0) begin errors++; $display("FAIL hit_clmulr_start got %b want 0", mif.unit_start); end
    next(); op_sel = 3;
    @(negedge clk);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL hit_reserved got %h want 0", res); end
    next(); req = 0;
    checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL hit_starts got %0d want 1", starts - s0); end
  endtask
  task automatic test_ext_stall;
    int n = 0;
    int s0 = starts;
    req = 1; op_sel = 0; op_a = 9; op_b = 6;
    for (int c = 0; c < 30 && (c == 0 || stall_req); c++) begin
      ext_stall = (c >= 2 && c <= 4);
      @(negedge clk);
      if (c == 3) begin
        checks++; if (mif.unit_stall !== 1'b1) begin errors++; $display("FAIL stall_unit_stall got %b want 1", mif.unit_stall); end
      end
      if (stall_req) n++;
      next();
    end
    ext_stall = 0;
    @(negedge clk);
    checks++; if (n !== 8) begin errors++; $display("FAIL stall_total got %0d want 8", n); end
    checks++; if (res !== 32'h36) begin errors++; $display("FAIL stall_res got %h want 36", res); end
    checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL stall_starts got %0d want 1", starts - s0); end
    next(); req = 0;
  endtask
  task automatic test_flush;
    int s0 = starts;
    req = 1; op_sel = 0; op_a = 7; op_b = 1;
    for (int c = 0; c <= 10; c++) begin
      flush = (c == 2);
      @(negedge clk);
      checks++; if (mif.unit_start !== (c == 0 || c == 5)) begin errors++; $display("FAIL flush_start c%0d got %b want %b", c, mif.unit_start, c == 0 || c == 5); end
      checks++; if (stall_req !== (c != 2 && c < 10)) begin errors++; $display("FAIL flush_stall c%0d got %b want %b", c, stall_req, c != 2 && c < 10); end
      if (c == 10) begin
        checks++; if (res !== 32'h7) begin errors++; $display("FAIL flush_res got %h want 7", res); end
      end
      next();
    end
    flush = 0; req = 0;
    checks++; if (starts - s0 !== 2) begin errors++; $display("FAIL flush_starts got %0d want 2", starts - s0); end
  endtask
  task automatic test_timeout;
    no_eoc = 1; req = 1; op_sel = 0; op_a = 5; op_b = 3;
    for (int c = 0; c <= 65; c++) begin
      @(negedge clk);
      if (c == 64) begin
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL tmo_stall64 got %b want 1", stall_req); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_err64 got %b want 0", err_timeout); end
      end
      if (c == 65) begin
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL tmo_stall65 got %b want 0", stall_req); end
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL tmo_res got %h want 0", res); end
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_err65 got %b want 1", err_timeout); end
      end
      next();
    end
    req = 0;
    next(); next(); next();
    @(negedge clk);
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b want 1", err_timeout); end
    no_eoc = 0;
  endtask
  task automatic test_reset_mid_op;
    int n = 0;
    int s0;
    next(); reset = 1; next(); reset = 0;
    @(negedge clk);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err_clear got %b want 0", err_timeout); end
    next();
    req = 1; op_a = 5; op_b = 3;
    @(negedge clk);
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL rst_cache_cleared got %b want 1", stall_req); end
    while (stall_req && n < 30) begin @(negedge clk); n++; end
    checks++; if (res !== 32'hF) begin errors++; $display("FAIL rst_res53 got %h want f", res); end
    next();
    s0 = starts;
    op_a = 32'hA; op_b = 3;
    for (int c = 0; c <= 3; c++) begin
      reset = (c == 2);
      @(negedge clk);
      if (c == 2) begin
        checks++; if (mif.unit_start !== 1'b0) begin errors++; $display("FAIL rst_mid_start got %b want 0", mif.unit_start); end
      end
      if (c == 3) begin
        checks++; if (mif.unit_start !== 1'b1) begin errors++; $display("FAIL rst_reissue got %b want 1", mif.unit_start); end
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL rst_reissue_stall got %b want 1", stall_req); end
      end
      if (c < 3) next();
    end
    n = 0;
    while (stall_req && n < 30) begin @(negedge clk); n++; end
    checks++; if (n !== 5) begin errors++; $display("FAIL rst_latency got %0d want 5", n); end
    checks++; if (res !== 32'h1E) begin errors++; $display("FAIL rst_res got %h want 1e", res); end
    checks++; if (starts - s0 !== 2) begin errors++; $display("FAIL rst_starts got %0d want 2", starts - s0); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL overlap got %0d want 0", overlap); end
    next(); req = 0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_cache_hit();
    test_ext_stall();
    test_flush();
    test_timeout();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
